config_loader: RTL and testbench

Bitstream loader that drives the serial configuration chain formed by the daisy-chained cell blocks (`prog_in` → `prog_out` of each block, in turn). It accepts configuration words over a valid/ready stream and serialises them LSB-first onto the chain with a gated `prog_en`. It then recirculates the chain once to verify the loaded contents against a CRC-8 without destroying them. It sits directly upstream of the first cell block, and the last block's `prog_out` returns to it.

---
 rtl/config_loader_pkg.sv | 21 ++
 rtl/config_loader_if.sv | 20 ++
 rtl/config_loader_crc8.sv | 24 ++
 rtl/config_loader.sv | 155 +++++++++++++++
 tb/tb_config_loader.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/config_loader_pkg.sv
// Shared types and the serial CRC-8 step used by the configuration loader.
package config_loader_pkg;

    // Loader sequencing: load the chain, recirculate it once, then report.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [7:0] CRC8_POLY = 8'h07;

    // One serial CRC-8 step, MSB feedback, polynomial x^8 + x^2 + x + 1.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
        logic fb;
        fb = crc[7] ^ din;
        return {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/config_loader_if.sv
// Valid/ready stream carrying configuration words into the loader.
interface config_loader_if #(
    parameter int WORD_W = 8
);
    logic [WORD_W-1:0] cfg_data;
    logic              cfg_valid;
    logic              cfg_ready;

    modport master (
        output cfg_data,
        output cfg_valid,
        input  cfg_ready
    );

    modport slave (
        input  cfg_data,
        input  cfg_valid,
        output cfg_ready
    );
endinterface

// File: rtl/config_loader_crc8.sv
// Serial CRC-8 accumulator: folds one bit per enabled cycle, clearable.
module cfg_crc8_serial
    import config_loader_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       clr,
    input  logic       din,
    output logic [7:0] crc
);

    // Clear has priority so a new load always starts from the zero seed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc <= 8'h00;
        end else if (clr) begin
            crc <= 8'h00;
        end else if (en) begin
            crc <= crc8_step(crc, din);
        end
    end

endmodule

// File: rtl/config_loader.sv
// Configuration chain loader: serialises stream words LSB-first onto the
// cell-block chain, then recirculates the chain once and compares CRCs of
// the bits sent and the bits read back.
module config_loader
    import config_loader_pkg::*;
#(
    parameter int CHAIN_LEN = 64,
    parameter int WORD_W    = 8
) (
    input  logic            prog_clk,
    input  logic            rst,
    input  logic            start,
    config_loader_if.slave  cfg,
    input  logic            chain_out,
    output logic            chain_in,
    output logic            prog_en,
    output logic            busy,
    output logic            done,
    output logic            error
);

    localparam int CNT_W = $clog2(CHAIN_LEN + 1);
    localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_W - 1);

    state_t             state;
    logic [WORD_W-1:0]  word_buf;
    logic               buf_vld;
    logic [IDX_W-1:0]   bit_idx;
    logic [CNT_W-1:0]   bit_cnt;

    logic               in_shift;
    logic               in_check;
    logic               launch;
    logic               last_bit;
    logic               word_end;
    logic               accept;
    logic               shift_bit;

    logic [7:0]         crc_a;
    logic [7:0]         crc_b;
    logic [7:0]         crc_b_next;

    assign in_shift = (state == ST_SHIFT);
    assign in_check = (state == ST_CHECK);
    assign launch   = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign last_bit = (bit_cnt == CNT_LAST);
    assign word_end = (bit_idx == IDX_LAST);

    // A refill is offered either into an empty buffer or on the final bit of
    // the current word, which keeps prog_en continuous across word
    // boundaries; nothing is taken once the last chain bit is in flight.
    assign cfg.cfg_ready = in_shift && (!buf_vld || (word_end && !last_bit));
    assign accept        = cfg.cfg_valid && cfg.cfg_ready;

    // The outputs depend on registers only, apart from the recirculation path.
    assign shift_bit = in_shift && buf_vld && word_buf[bit_idx];
    assign prog_en   = (in_shift && buf_vld) || in_check;
    assign chain_in  = in_check ? chain_out : shift_bit;
    assign busy      = in_shift || in_check;

    // The final comparison needs the read-back CRC including this cycle's bit.
    assign crc_b_next = crc8_step(crc_b, chain_out);

    cfg_crc8_serial u_crc_a (
        .clk (prog_clk),
        .rst (rst),
        .en  (in_shift && buf_vld),
        .clr (launch),
        .din (shift_bit),
        .crc (crc_a)
    );

    cfg_crc8_serial u_crc_b (
        .clk (prog_clk),
        .rst (rst),
        .en  (in_check),
        .clr (launch),
        .din (chain_out),
        .crc (crc_b)
    );

    // Control FSM: state, word-buffer occupancy, bit index/counter and status.
    always_ff @(posedge prog_clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            buf_vld <= 1'b0;
            bit_idx <= '0;
            bit_cnt <= '0;
            done    <= 1'b0;
            error   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state   <= ST_SHIFT;
                        buf_vld <= 1'b0;
                        bit_idx <= '0;
                        bit_cnt <= '0;
                        done    <= 1'b0;
                        error   <= 1'b0;
                    end
                end

                ST_SHIFT: begin
                    if (buf_vld) begin
                        bit_cnt <= bit_cnt + 1'b1;
                        if (last_bit) begin
                            // Chain full: leftover MSBs of the last word are dropped.
                            state   <= ST_CHECK;
                            bit_cnt <= '0;
                            bit_idx <= '0;
                            buf_vld <= 1'b0;
                        end else if (word_end) begin
                            bit_idx <= '0;
                            buf_vld <= accept;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else if (accept) begin
                        buf_vld <= 1'b1;
                        bit_idx <= '0;
                    end
                end

                ST_CHECK: begin
                    if (last_bit) begin
                        state   <= ST_DONE;
                        bit_cnt <= '0;
                        done    <= 1'b1;
                        error   <= (crc_a != crc_b_next);
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Word buffer data: zeroed on launch, loaded on every accepted word.
    always_ff @(posedge prog_clk) begin
        if (launch) begin
            word_buf <= '0;
        end else if (accept) begin
            word_buf <= cfg.cfg_data;
        end
    end

endmodule

// File: tb/tb_config_loader.sv
// Bench for config_loader with a 20-bit behavioural cell chain.
module tb_config_loader;

    localparam int CL     = 20;
    localparam int BUDGET = 300;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic chain_out;
    logic chain_in;
    logic prog_en;
    logic busy;
    logic done;
    logic error;

    config_loader_if #(.WORD_W(8)) cfg_if ();

    config_loader #(
        .CHAIN_LEN (CL),
        .WORD_W    (8)
    ) dut (
        .prog_clk  (clk),
        .rst       (rst),
        .start     (start),
        .cfg       (cfg_if),
        .chain_out (chain_out),
        .chain_in  (chain_in),
        .prog_en   (prog_en),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    // Chain model: prog_in enters at bit 19, prog_out is bit 0. flip_mask
    // injects a one-shot upset that the next edge stores into the chain.
    logic [CL-1:0] chain     = '0;
    logic [CL-1:0] flip_mask = '0;
    logic [CL-1:0] eff;
    assign eff       = chain ^ flip_mask;
    assign chain_out = eff[0];

    always @(posedge clk) begin
        chain <= prog_en ? {chain_in, eff[CL-1:1]} : eff;
    end

    int checks = 0;
    int errors = 0;
    bit exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic run_load(input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2,
                            input int gap, input bit flip, input int rst_at, input bit poke);
        logic [7:0]    words [3];
        logic [23:0]   cat;
        logic [CL-1:0] chain_prev;
        int            widx, pushed, pe_cnt, bubbles, cyc, gap_left;
        bit            prev_pe, prev_busy, aborted;

        words[0] = w0; words[1] = w1; words[2] = w2;
        cat = {w2, w1, w0};
        widx = 0; pushed = 0; pe_cnt = 0; bubbles = 0; cyc = 0; gap_left = gap;
        prev_pe = 1'b0; prev_busy = 1'b0; aborted = 1'b0; chain_prev = chain;
        exp_q.delete();

        cfg_if.cfg_valid = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("start_state", 32'({busy, done, error, prog_en}), 32'b1000);

        while (!done && cyc < BUDGET && !aborted) begin
            if (cyc > 0 && prev_busy && !prev_pe)
                check_eq("hold_chain", 32'(chain), 32'(chain_prev));

            if (rst_at > 0 && pe_cnt == rst_at) begin
                cfg_if.cfg_valid = 1'b1;
                rst = 1'b1;
                #1;
                check_eq("rst_outs", 32'({prog_en, chain_in, busy, done, error, cfg_if.cfg_ready}), 0);
                @(negedge clk);
                rst = 1'b0;
                cfg_if.cfg_valid = 1'b0;
                #1;
                check_eq("rst_idle", 32'({prog_en, busy, done, error}), 0);
                aborted = 1'b1;
            end else begin
                // Observe this cycle's outputs against the scoreboard.
                if (prog_en) begin
                    if (pe_cnt < CL) begin
                        if (exp_q.size() == 0)
                            check_eq("sb_extra_bit", 32'(prog_en), 0);
                        else
                            check_eq("shift_bit", 32'(chain_in), 32'(exp_q.pop_front()));
                    end else begin
                        check_eq("recirc", 32'(chain_in), 32'(chain_out));
                    end
                    pe_cnt++;
                end else if (busy && pe_cnt > 0) begin
                    bubbles++;
                end

                flip_mask = (flip && pe_cnt == CL + 3) ? CL'(20'h00080) : '0;
                start     = poke && (pe_cnt == 5 || pe_cnt == CL + 5);

                // Drive the stream; gap counts ready cycles with valid held low.
                cfg_if.cfg_valid = 1'b0;
                if (widx < 3) begin
                    if (widx == 1 && gap_left > 0) begin
                        if (cfg_if.cfg_ready) gap_left--;
                    end else begin
                        cfg_if.cfg_valid = 1'b1;
                        cfg_if.cfg_data  = words[widx];
                    end
                end
                if (cfg_if.cfg_valid && cfg_if.cfg_ready) begin
                    for (int b = 0; b < 8; b++) begin
                        if (pushed < CL) begin
                            exp_q.push_back(words[widx][b]);
                            pushed++;
                        end
                    end
                    widx++;
                end

                prev_pe    = prog_en;
                prev_busy  = busy;
                chain_prev = chain;
                @(negedge clk);
                cyc++;
            end
        end

        start = 1'b0;
        flip_mask = '0;
        if (!aborted) begin
            check_eq("done",      32'(done), 1);
            check_eq("error",     32'(error), 32'(flip));
            check_eq("busy_end",  32'(busy), 0);
            check_eq("pe_count",  32'(pe_cnt), 32'(2 * CL));
            check_eq("latency",   32'(cyc), 32'(2 * CL + 1 + gap));
            check_eq("bubbles",   32'(bubbles), 32'(gap));
            check_eq("sb_left",   32'(exp_q.size()), 0);
            if (!flip)
                check_eq("chain", 32'(chain), 32'(cat[CL-1:0]));
            cfg_if.cfg_valid = 1'b1;
            #1;
            check_eq("done_ready", 32'(cfg_if.cfg_ready), 0);
            cfg_if.cfg_valid = 1'b0;
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_data  = 8'h5A;
        repeat (3) @(negedge clk);
        check_eq("reset_outs",  32'({prog_en, chain_in, busy, done, error}), 0);
        check_eq("reset_ready", 32'(cfg_if.cfg_ready), 0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("idle_ready", 32'({cfg_if.cfg_ready, busy, prog_en}), 0);
        cfg_if.cfg_valid = 1'b0;

        run_load(8'hA5, 8'h3C, 8'hFF, 0, 1'b0, 0, 1'b0);   // back-to-back
        run_load(8'hA5, 8'h3C, 8'h0F, 0, 1'b0, 0, 1'b0);   // unused MSBs differ
        run_load(8'hA5, 8'h3C, 8'hFF, 5, 1'b0, 0, 1'b0);   // starvation
        run_load(8'hA5, 8'h3C, 8'hFF, 0, 1'b1, 0, 1'b0);   // upset during CHECK
        run_load(8'h5A, 8'hC3, 8'h96, 0, 1'b0, 0, 1'b1);   // from DONE w/ error, start pokes
        run_load(8'h12, 8'h34, 8'h56, 0, 1'b0, 10, 1'b0);  // reset after 10 shifts
        run_load(8'hA5, 8'h3C, 8'hFF, 0, 1'b0, 0, 1'b0);   // fresh load after reset

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
